// File: rtl/stdp_pulse_gen.sv
// STDP pulse generator: records the first pre/post spike times in each gamma window and
// issues a single saturating inc or dec pulse to the downstream weight counter.
module stdp_pulse_gen #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned GAMMA_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gamma_start,
    input  logic             in_spike,
    input  logic             out_spike,
    input  logic [WIDTH-1:0] weight,
    output logic             inc,
    output logic             dec,
    output logic             busy
);

    localparam int unsigned TW = $clog2(GAMMA_LEN);
    localparam logic [TW-1:0]    LAST_TIME = TW'(GAMMA_LEN - 1);
    localparam logic [WIDTH-1:0] WMAX      = '1;

    typedef enum logic [1:0] {IDLE, OBSERVE, DECIDE, EMIT} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic            in_seen, in_seen_n;
    logic            out_seen, out_seen_n;
    logic [TW-1:0]   t_in, t_in_n;
    logic [TW-1:0]   t_out, t_out_n;
    logic            inc_n, dec_n, busy_n;

    logic            capture;
    logic [TW-1:0]   cur_time;
    logic            in_armed, out_armed;
    logic            want_inc, want_dec;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            in_seen  <= 1'b0;
            out_seen <= 1'b0;
            t_in     <= '0;
            t_out    <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            in_seen  <= in_seen_n;
            out_seen <= out_seen_n;
            t_in     <= t_in_n;
            t_out    <= t_out_n;
            inc      <= inc_n;
            dec      <= dec_n;
            busy     <= busy_n;
        end
    end

    // Next state, spike capture and STDP decision
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        in_seen_n  = in_seen;
        out_seen_n = out_seen;
        t_in_n     = t_in;
        t_out_n    = t_out;
        inc_n      = 1'b0;
        dec_n      = 1'b0;

        // gamma_start always opens a fresh window at time 0, whatever the state
        capture   = gamma_start || (state == OBSERVE);
        cur_time  = gamma_start ? '0 : timer;
        in_armed  = gamma_start ? 1'b1 : !in_seen;
        out_armed = gamma_start ? 1'b1 : !out_seen;

        if (gamma_start) begin
            in_seen_n  = 1'b0;
            out_seen_n = 1'b0;
            t_in_n     = '0;
            t_out_n    = '0;
        end
        if (capture && in_spike && in_armed) begin
            in_seen_n = 1'b1;
            t_in_n    = cur_time;
        end
        if (capture && out_spike && out_armed) begin
            out_seen_n = 1'b1;
            t_out_n    = cur_time;
        end

        want_inc = in_seen && (!out_seen || (t_in <= t_out));
        want_dec = out_seen && (!in_seen || (t_in > t_out));

        if (gamma_start) begin
            state_n = OBSERVE;
            timer_n = TW'(1);
        end else begin
            case (state)
                IDLE: begin
                    timer_n = '0;
                end
                OBSERVE: begin
                    if (timer == LAST_TIME) begin
                        state_n = DECIDE;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                DECIDE: begin
                    state_n = EMIT;
                    inc_n   = want_inc && (weight != WMAX);
                    dec_n   = want_dec && (weight != '0);
                end
                EMIT: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

endmodule
